robot_motion_scheduler: RTL and testbench
=========================================

// Module: robot_motion_scheduler
// PURPOSE
//   Sequences the 3-bit robot FSM state consumed by the motor output decoder.
//   Arbitrates motion commands from a host and an obstacle-avoid requester, with
//   avoid having priority. Enforces minimum dwell per motion, a timed STOP brake
//   before any reversal or stop, a command watchdog, and fault ERROR/RECOVER sequencing.
// PARAMETERS
//   DWELL_CYC    8     min cycles in a motion state before a new command is accepted (>=1)
//   STOP_CYC     4     cycles held in STOP (brake) on stop/reversal/watchdog (>=1)
//   WDOG_CYC     1000  cycles in motion with no accepted command before forced STOP
//   RECOVER_CYC  16    cycles held in RECOVER after fault clear
// PORTS
//   clk             in   1  system clock, all flops rising edge
//   rst_n           in   1  asynchronous active-low reset
//   host_cmd_valid  in   1  host command valid
//   host_cmd        in   3  host command, state encoding
//   host_cmd_ready  out  1  host command accepted when valid&&ready
//   avoid_req       in   1  obstacle-avoid command request (level, held until ack)
//   avoid_cmd       in   3  avoid command, state encoding
//   avoid_ack       out  1  1-cycle pulse: avoid command consumed
//   fault           in   1  hard fault, level
//   fault_clr       in   1  1-cycle fault-clear request
//   state           out  3  registered FSM state to the output decoder
//   busy            out  1  state is STOP or RECOVER
//   err_flag        out  1  state is ERROR
//   illegal_cmd     out  1  1-cycle pulse: consumed command had an illegal code
// BEHAVIOUR
//   Encoding: IDLE=0 FORWARD=1 BACKWARD=2 LEFT=3 RIGHT=4 STOP=5 ERROR=6 RECOVER=7.
//   Legal commands are 1..5. Codes 0, 6 and 7 are consumed with no state effect
//     and pulse illegal_cmd on the next cycle.
//   Reset (async, any time, including mid-brake or mid-recover):
//     state=IDLE, all counters=0, pending target cleared, every output 0.
//     en flop=0, then 1 on the first clock edge after release.
//     Earliest acceptance is therefore the 2nd edge after release.
//   can_accept = en & ~fault & (state==IDLE | (motion state & dwell_done)).
//     Never true in STOP, ERROR or RECOVER.
//   Arbitration (combinational):
//     avoid_take = can_accept & avoid_req.
//     host_cmd_ready = can_accept & ~avoid_req.
//     avoid_ack is a registered pulse of avoid_take; the requester drops avoid_req
//       on the ack. Ack latency is 1 cycle, so can_accept is also gated low on the
//       cycle avoid_ack is high, which prevents a double-take.
//   Command effect on the accept edge; new state is visible the next cycle.
//   Command C accepted in state S:
//     S=IDLE: C motion -> C. C=STOP -> STOP, no pending target.
//     S motion, C==S: stay; reset the watchdog only (dwell not restarted).
//     S motion, C=STOP: -> STOP, no pending target.
//     S motion, C is the reverse of S (FWD<->BWD, LEFT<->RIGHT): -> STOP, pending=C.
//     S motion, any other motion C: -> C directly.
//   Entering a motion state clears the dwell and watchdog counters.
//     dwell_cnt counts up and saturates at DWELL_CYC. dwell_done = (dwell_cnt==DWELL_CYC).
//   STOP: counts STOP_CYC cycles, then -> pending target (cleared) if set, else IDLE.
//   Watchdog: in motion only, counts cycles since entry or last accepted command.
//     At WDOG_CYC it forces STOP with no pending target.
//     An accept on the expiry cycle wins and restarts the watchdog.
//   fault=1 in any state forces ERROR on the next edge. It is the highest priority,
//     clears pending and aborts STOP/RECOVER.
//   ERROR: hold until fault_clr=1 while fault=0 -> RECOVER. fault_clr with fault=1 is ignored.
//   RECOVER: RECOVER_CYC cycles -> IDLE. A fault here returns to ERROR.
//   Counter widths are $clog2(param+1) and saturate; no wrap-around.
// TESTING (defaults unless noted)
//   Reset release, host FORWARD valid from cycle 0 -> ready low for the 1st edge,
//     accepted on the 2nd, state=1 the following cycle.
//   FORWARD then host BACKWARD -> ready low for 8 cycles. On accept: state=5 for
//     4 cycles, then 2, busy=1 for exactly 4 cycles.
//   FORWARD, host LEFT and avoid RIGHT presented together after dwell -> avoid_ack
//     pulses, state=4, host_cmd_ready=0 that cycle, LEFT taken after a further 8 cycles.
//   FORWARD with no commands, WDOG_CYC=20 -> state=5 at cycle 20, IDLE 4 cycles later.
//   fault during STOP brake -> state=6, err_flag=1. fault_clr with fault=1 is ignored.
//     fault_clr with fault=0 -> 7 for 16 cycles, then 0.
//   host cmd=6 in IDLE -> consumed, illegal_cmd 1-cycle pulse, state stays 0.
//     rst_n low mid-RECOVER -> immediately 0 with all outputs 0.

Source files
------------

// File: rtl/robot_motion_scheduler.sv
// Motion-state sequencer for the motor output decoder: arbitrates host and
// obstacle-avoid commands, enforces dwell, brake, watchdog and fault recovery.
module robot_motion_scheduler #(
  parameter int unsigned DWELL_CYC   = 8,
  parameter int unsigned STOP_CYC    = 4,
  parameter int unsigned WDOG_CYC    = 1000,
  parameter int unsigned RECOVER_CYC = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       host_cmd_valid,
  input  logic [2:0] host_cmd,
  output logic       host_cmd_ready,
  input  logic       avoid_req,
  input  logic [2:0] avoid_cmd,
  output logic       avoid_ack,
  input  logic       fault,
  input  logic       fault_clr,
  output logic [2:0] state,
  output logic       busy,
  output logic       err_flag,
  output logic       illegal_cmd
);

  localparam int unsigned DW = $clog2(DWELL_CYC + 1);
  localparam int unsigned SW = $clog2(STOP_CYC + 1);
  localparam int unsigned WW = $clog2(WDOG_CYC + 1);
  localparam int unsigned RW = $clog2(RECOVER_CYC + 1);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_FWD     = 3'd1,
    S_BWD     = 3'd2,
    S_LEFT    = 3'd3,
    S_RIGHT   = 3'd4,
    S_STOP    = 3'd5,
    S_ERROR   = 3'd6,
    S_RECOVER = 3'd7
  } state_t;

  state_t        cur, nxt, cmd, pend, pend_nxt;
  logic          pend_vld, pend_vld_nxt;
  logic          en;
  logic [DW-1:0] dwell_cnt;
  logic [SW-1:0] stop_cnt;
  logic [WW-1:0] wdog_cnt;
  logic [RW-1:0] rec_cnt;
  logic          motion, dwell_done, can_accept, avoid_take, take, cmd_legal;
  logic          wdog_exp, stop_done, rec_done, wdog_kick, entering;

  function automatic state_t reverse_of(input state_t s);
    case (s)
      S_FWD:   return S_BWD;
      S_BWD:   return S_FWD;
      S_LEFT:  return S_RIGHT;
      S_RIGHT: return S_LEFT;
      default: return s;
    endcase
  endfunction

  assign state = cur;

  // Arbitration and next-state; ack gating stops a held avoid_req being taken twice
  always_comb begin
    motion         = cur inside {S_FWD, S_BWD, S_LEFT, S_RIGHT};
    dwell_done     = (dwell_cnt == DW'(DWELL_CYC));
    can_accept     = en & ~fault & ~avoid_ack & ((cur == S_IDLE) | (motion & dwell_done));
    avoid_take     = can_accept & avoid_req;
    host_cmd_ready = can_accept & ~avoid_req;
    take           = avoid_take | (host_cmd_ready & host_cmd_valid);
    cmd            = state_t'(avoid_take ? avoid_cmd : host_cmd);
    cmd_legal      = cmd inside {S_FWD, S_BWD, S_LEFT, S_RIGHT, S_STOP};
    wdog_exp       = motion & (wdog_cnt == WW'(WDOG_CYC - 1));
    stop_done      = (stop_cnt == SW'(STOP_CYC - 1));
    rec_done       = (rec_cnt == RW'(RECOVER_CYC - 1));
    nxt            = cur;
    pend_nxt       = pend;
    pend_vld_nxt   = pend_vld;
    wdog_kick      = 1'b0;
    if (fault) begin
      nxt          = S_ERROR;
      pend_vld_nxt = 1'b0;
    end else begin
      case (cur)
        S_IDLE: begin
          if (take && cmd_legal) begin
            nxt          = cmd;
            pend_vld_nxt = 1'b0;
          end
        end
        S_FWD, S_BWD, S_LEFT, S_RIGHT: begin
          if (take && cmd_legal) begin
            if (cmd == cur) begin
              wdog_kick = 1'b1;
            end else if (cmd == S_STOP) begin
              nxt          = S_STOP;
              pend_vld_nxt = 1'b0;
            end else if (cmd == reverse_of(cur)) begin
              nxt          = S_STOP;
              pend_nxt     = cmd;
              pend_vld_nxt = 1'b1;
            end else begin
              nxt = cmd;
            end
          end else if (wdog_exp) begin
            nxt          = S_STOP;
            pend_vld_nxt = 1'b0;
          end
        end
        S_STOP: begin
          if (stop_done) begin
            nxt          = pend_vld ? pend : S_IDLE;
            pend_vld_nxt = 1'b0;
          end
        end
        S_ERROR: begin
          if (fault_clr) nxt = S_RECOVER;
        end
        S_RECOVER: begin
          if (rec_done) nxt = S_IDLE;
        end
        default: nxt = S_IDLE;
      endcase
    end
    entering = (nxt != cur);
  end

  // State, counters and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur         <= S_IDLE;
      pend        <= S_IDLE;
      pend_vld    <= 1'b0;
      en          <= 1'b0;
      dwell_cnt   <= '0;
      stop_cnt    <= '0;
      wdog_cnt    <= '0;
      rec_cnt     <= '0;
      avoid_ack   <= 1'b0;
      illegal_cmd <= 1'b0;
      busy        <= 1'b0;
      err_flag    <= 1'b0;
    end else begin
      en          <= 1'b1;
      cur         <= nxt;
      pend        <= pend_nxt;
      pend_vld    <= pend_vld_nxt;
      avoid_ack   <= avoid_take;
      illegal_cmd <= take & ~cmd_legal;
      busy        <= (nxt == S_STOP) || (nxt == S_RECOVER);
      err_flag    <= (nxt == S_ERROR);

      if (entering)                    dwell_cnt <= '0;
      else if (motion && !dwell_done)  dwell_cnt <= dwell_cnt + DW'(1);

      if (entering || wdog_kick)                       wdog_cnt <= '0;
      else if (motion && wdog_cnt != WW'(WDOG_CYC))    wdog_cnt <= wdog_cnt + WW'(1);

      if (entering)                                      stop_cnt <= '0;
      else if (cur == S_STOP && stop_cnt != SW'(STOP_CYC)) stop_cnt <= stop_cnt + SW'(1);

      if (entering)                                           rec_cnt <= '0;
      else if (cur == S_RECOVER && rec_cnt != RW'(RECOVER_CYC)) rec_cnt <= rec_cnt + RW'(1);
    end
  end

endmodule

// File: tb/tb_robot_motion_scheduler.sv
// Directed bench for robot_motion_scheduler (watchdog shortened to 20 cycles).
module tb_robot_motion_scheduler;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       host_cmd_valid;
  logic [2:0] host_cmd;
  logic       host_cmd_ready;
  logic       avoid_req;
  logic [2:0] avoid_cmd;
  logic       avoid_ack;
  logic       fault;
  logic       fault_clr;
  logic [2:0] state;
  logic       busy;
  logic       err_flag;
  logic       illegal_cmd;

  int checks = 0;
  int errors = 0;

  robot_motion_scheduler #(
    .DWELL_CYC(8), .STOP_CYC(4), .WDOG_CYC(20), .RECOVER_CYC(16)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .host_cmd_valid(host_cmd_valid), .host_cmd(host_cmd), .host_cmd_ready(host_cmd_ready),
    .avoid_req(avoid_req), .avoid_cmd(avoid_cmd), .avoid_ack(avoid_ack),
    .fault(fault), .fault_clr(fault_clr),
    .state(state), .busy(busy), .err_flag(err_flag), .illegal_cmd(illegal_cmd)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    host_cmd_valid = 1'b0; host_cmd = 3'd0;
    avoid_req = 1'b0; avoid_cmd = 3'd0;
    fault = 1'b0; fault_clr = 1'b0;
    #3;
    rst_n = 1'b1;
  endtask

  // Reset, then FORWARD accepted on the 2nd edge; returns on the first FORWARD cycle
  task automatic go_forward();
    do_reset();
    host_cmd_valid = 1'b1; host_cmd = 3'd1;
    step();
    step();
    host_cmd_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    host_cmd_valid = 1'b1; host_cmd = 3'd1;
    avoid_req = 1'b0; avoid_cmd = 3'd0;
    fault = 1'b0; fault_clr = 1'b0;
    #12;
    checks++;
    if ({state, busy, err_flag, avoid_ack, illegal_cmd, host_cmd_ready} !== 8'd0) begin
      errors++;
      $display("FAIL reset_outputs got %b exp 0",
               {state, busy, err_flag, avoid_ack, illegal_cmd, host_cmd_ready});
    end
    @(posedge clk); #1;
    rst_n = 1'b1;
    #1;
    checks++;
    if (host_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL ready_before_en got %b exp 0", host_cmd_ready);
    end
    step();
    checks++;
    if (host_cmd_ready !== 1'b1 || state !== 3'd0) begin
      errors++; $display("FAIL ready_after_en got rdy=%b st=%0d exp rdy=1 st=0", host_cmd_ready, state);
    end
    step();
    host_cmd_valid = 1'b0;
    checks++;
    if (state !== 3'd1) begin
      errors++; $display("FAIL first_accept got %0d exp 1", state);
    end
  endtask

  task automatic test_back_to_back();
    host_cmd_valid = 1'b1; host_cmd = 3'd2;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (host_cmd_ready !== 1'b0) begin
        errors++; $display("FAIL dwell_ready_low cyc=%0d got %b exp 0", i, host_cmd_ready);
      end
      step();
    end
    checks++;
    if (host_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL dwell_ready_high got %b exp 1", host_cmd_ready);
    end
    step();
    host_cmd_valid = 1'b0;
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 3'd5 || busy !== 1'b1) begin
        errors++; $display("FAIL reversal_brake cyc=%0d got st=%0d busy=%b exp st=5 busy=1", i, state, busy);
      end
      step();
    end
    checks++;
    if (state !== 3'd2 || busy !== 1'b0) begin
      errors++; $display("FAIL reversal_target got st=%0d busy=%b exp st=2 busy=0", state, busy);
    end
  endtask

  task automatic test_avoid_priority();
    go_forward();
    repeat (8) step();
    host_cmd_valid = 1'b1; host_cmd = 3'd3;
    avoid_req = 1'b1; avoid_cmd = 3'd4;
    #1;
    checks++;
    if (host_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL avoid_masks_host got %b exp 0", host_cmd_ready);
    end
    step();
    checks++;
    if (avoid_ack !== 1'b1 || state !== 3'd4 || host_cmd_ready !== 1'b0) begin
      errors++; $display("FAIL avoid_take got ack=%b st=%0d rdy=%b exp ack=1 st=4 rdy=0",
                         avoid_ack, state, host_cmd_ready);
    end
    avoid_req = 1'b0;
    #1;
    for (int i = 0; i < 8; i++) begin
      checks++;
      if (host_cmd_ready !== 1'b0) begin
        errors++; $display("FAIL avoid_dwell cyc=%0d got %b exp 0", i, host_cmd_ready);
      end
      step();
      if (i == 0) begin
        checks++;
        if (avoid_ack !== 1'b0) begin
          errors++; $display("FAIL ack_pulse_width got %b exp 0", avoid_ack);
        end
      end
    end
    checks++;
    if (host_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL host_left_ready got %b exp 1", host_cmd_ready);
    end
    step();
    host_cmd_valid = 1'b0;
    checks++;
    if (state !== 3'd5) begin
      errors++; $display("FAIL left_reversal_brake got %0d exp 5", state);
    end
    repeat (4) step();
    checks++;
    if (state !== 3'd3) begin
      errors++; $display("FAIL left_after_brake got %0d exp 3", state);
    end
  endtask

  task automatic test_watchdog();
    go_forward();
    for (int i = 0; i < 20; i++) begin
      checks++;
      if (state !== 3'd1) begin
        errors++; $display("FAIL wdog_motion cyc=%0d got %0d exp 1", i, state);
      end
      step();
    end
    for (int i = 0; i < 4; i++) begin
      checks++;
      if (state !== 3'd5) begin
        errors++; $display("FAIL wdog_stop cyc=%0d got %0d exp 5", i, state);
      end
      step();
    end
    checks++;
    if (state !== 3'd0) begin
      errors++; $display("FAIL wdog_idle got %0d exp 0", state);
    end
  endtask

  task automatic test_fault();
    go_forward();
    repeat (8) step();
    host_cmd_valid = 1'b1; host_cmd = 3'd5;
    step();
    host_cmd_valid = 1'b0;
    checks++;
    if (state !== 3'd5) begin
      errors++; $display("FAIL host_stop got %0d exp 5", state);
    end
    fault = 1'b1;
    step();
    checks++;
    if (state !== 3'd6 || err_flag !== 1'b1 || busy !== 1'b0) begin
      errors++; $display("FAIL fault_in_brake got st=%0d err=%b busy=%b exp st=6 err=1 busy=0",
                         state, err_flag, busy);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    fault = 1'b0;
    step();
    checks++;
    if (state !== 3'd6) begin
      errors++; $display("FAIL clr_during_fault got %0d exp 6", state);
    end
    fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (state !== 3'd7 || busy !== 1'b1 || err_flag !== 1'b0) begin
        errors++; $display("FAIL recover cyc=%0d got st=%0d busy=%b exp st=7 busy=1", i, state, busy);
      end
      step();
    end
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL recover_done got st=%0d busy=%b exp st=0 busy=0", state, busy);
    end
  endtask

  task automatic test_illegal();
    host_cmd_valid = 1'b1; host_cmd = 3'd6;
    #1;
    checks++;
    if (host_cmd_ready !== 1'b1) begin
      errors++; $display("FAIL illegal_ready got %b exp 1", host_cmd_ready);
    end
    step();
    host_cmd_valid = 1'b0;
    checks++;
    if (illegal_cmd !== 1'b1 || state !== 3'd0) begin
      errors++; $display("FAIL illegal_pulse got ill=%b st=%0d exp ill=1 st=0", illegal_cmd, state);
    end
    step();
    checks++;
    if (illegal_cmd !== 1'b0) begin
      errors++; $display("FAIL illegal_width got %b exp 0", illegal_cmd);
    end
  endtask

  task automatic test_reset_mid_recover();
    fault = 1'b1;
    step();
    fault = 1'b0; fault_clr = 1'b1;
    step();
    fault_clr = 1'b0;
    repeat (3) step();
    checks++;
    if (state !== 3'd7) begin
      errors++; $display("FAIL reach_recover got %0d exp 7", state);
    end
    #2;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({state, busy, err_flag, avoid_ack, illegal_cmd, host_cmd_ready} !== 8'd0) begin
      errors++;
      $display("FAIL reset_mid_recover got %b exp 0",
               {state, busy, err_flag, avoid_ack, illegal_cmd, host_cmd_ready});
    end
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_avoid_priority();
    test_watchdog();
    test_fault();
    test_illegal();
    test_reset_mid_recover();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
